// File: rtl/quant_coef_serializer.sv
// quant_coef_serializer: sign-magnitude conversion of quantized L/H pairs into a FWFT coefficient FIFO
module quant_coef_serializer #(
  parameter int DEPTH = 8,
  parameter int MW = 15
) (
  input  logic          clk_qk,
  input  logic          rst,
  input  logic          rst_syn,
  input  logic [16:0]   quant_out_l,
  input  logic [16:0]   quant_out_h,
  input  logic          quant_out_vld,
  input  logic          dwt_work,
  output logic [MW:0]   coef_out,
  output logic          coef_lane,
  output logic          coef_vld,
  input  logic          coef_rdy,
  output logic          fifo_full,
  output logic          ovf_err,
  output logic [MW-1:0] mag_or,
  input  logic          mag_or_clr
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [MW+1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count, count_nxt;
  logic [MW:0]   cl, ch;
  logic [MW+1:0] head;
  logic          wr_req, push, pop;
  function automatic logic [MW:0] conv(input logic [16:0] x);
    logic [17:0] e, m;
    e = {x[16], x};
    m = x[16] ? 18'(-e) : e;
    return {x[16], (m > 18'((1 << MW) - 1)) ? {MW{1'b1}} : m[MW-1:0]};
  endfunction
  assign cl        = conv(quant_out_l);
  assign ch        = conv(quant_out_h);
  assign wr_req    = quant_out_vld && dwt_work;
  assign push      = wr_req && (count <= CW'(DEPTH - 2));
  assign pop       = coef_vld && coef_rdy;
  assign count_nxt = count + (push ? CW'(2) : CW'(0)) - CW'(pop);
  assign head      = mem[rd_ptr];
  assign coef_vld  = count != '0;
  assign coef_out  = coef_vld ? head[MW:0] : '0;
  assign coef_lane = coef_vld && head[MW+1];
  // storage: L lands at wr_ptr, H at the next slot (wrapping), tagged with its lane
  always_ff @(posedge clk_qk) begin
    if (push) begin
      mem[wr_ptr]          <= {1'b0, cl};
      mem[wr_ptr + AW'(1)] <= {1'b1, ch};
    end
  end
  // pointers, occupancy, flags and magnitude accumulator
  always_ff @(posedge clk_qk or negedge rst) begin
    if (!rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      fifo_full <= 1'b0;
      ovf_err   <= 1'b0;
      mag_or    <= '0;
    end else if (rst_syn) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      fifo_full <= 1'b0;
      ovf_err   <= 1'b0;
      mag_or    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(2);
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      count     <= count_nxt;
      fifo_full <= count_nxt > CW'(DEPTH - 2);
      if (wr_req && !push) ovf_err <= 1'b1;
      if (push) mag_or <= (mag_or_clr ? '0 : mag_or) | cl[MW-1:0] | ch[MW-1:0];
      else if (mag_or_clr) mag_or <= '0;
    end
  end
endmodule

// File: tb/tb_quant_coef_serializer.sv
// tb_quant_coef_serializer: directed scoreboard bench for quant_coef_serializer
module tb_quant_coef_serializer;
  logic        clk_qk = 1'b0;
  logic        rst, rst_syn;
  logic [16:0] quant_out_l, quant_out_h;
  logic        quant_out_vld, dwt_work, coef_rdy, mag_or_clr;
  logic [15:0] coef_out;
  logic        coef_lane, coef_vld, fifo_full, ovf_err;
  logic [14:0] mag_or;
  logic [16:0] q[$];
  logic [16:0] exp_e;
  logic [14:0] exp_or;
  int compared = 0;
  int mismatched = 0;

  quant_coef_serializer #(.DEPTH(8), .MW(15)) dut (
    .clk_qk(clk_qk), .rst(rst), .rst_syn(rst_syn),
    .quant_out_l(quant_out_l), .quant_out_h(quant_out_h),
    .quant_out_vld(quant_out_vld), .dwt_work(dwt_work),
    .coef_out(coef_out), .coef_lane(coef_lane), .coef_vld(coef_vld),
    .coef_rdy(coef_rdy), .fifo_full(fifo_full), .ovf_err(ovf_err),
    .mag_or(mag_or), .mag_or_clr(mag_or_clr)
  );

  always #5 clk_qk = ~clk_qk;

  function automatic logic [15:0] ref_coef(input int x);
    int m;
    m = (x < 0) ? -x : x;
    if (m > 32767) m = 32767;
    return {(x < 0) ? 1'b1 : 1'b0, m[14:0]};
  endfunction

  task automatic tick;
    @(posedge clk_qk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic pair(input int l, input int h, input bit acc, input bit work);
    logic [15:0] rl, rh;
    rl = ref_coef(l);
    rh = ref_coef(h);
    quant_out_l = 17'(l);
    quant_out_h = 17'(h);
    quant_out_vld = 1'b1;
    dwt_work = work;
    if (acc) begin
      q.push_back({1'b0, rl});
      q.push_back({1'b1, rh});
      exp_or = (mag_or_clr ? 15'd0 : exp_or) | rl[14:0] | rh[14:0];
    end
    tick;
    quant_out_vld = 1'b0;
    dwt_work = 1'b0;
  endtask

  always @(negedge clk_qk) begin
    if (rst && !rst_syn && coef_vld && coef_rdy) begin
      compared++;
      assert (q.size() != 0) else begin
        mismatched++;
        $error("FAIL sb_unexpected observed=%h expected=none", {coef_lane, coef_out});
      end
      if (q.size() != 0) begin
        exp_e = q.pop_front();
        compared++;
        assert ({coef_lane, coef_out} === exp_e) else begin
          mismatched++;
          $error("FAIL sb_pop observed=%h expected=%h", {coef_lane, coef_out}, exp_e);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; rst_syn = 1'b0; quant_out_l = '0; quant_out_h = '0;
    quant_out_vld = 1'b0; dwt_work = 1'b0; coef_rdy = 1'b0; mag_or_clr = 1'b0;
    exp_or = '0;
    tick; tick;
    chk("rst_vld", 32'(coef_vld), 0);
    chk("rst_out", 32'(coef_out), 0);
    chk("rst_lane", 32'(coef_lane), 0);
    chk("rst_full", 32'(fifo_full), 0);
    chk("rst_ovf", 32'(ovf_err), 0);
    chk("rst_mag_or", 32'(mag_or), 0);
    rst = 1'b1;
    tick;
    // basic pair with consumer ready
    coef_rdy = 1'b1;
    pair(5, -3, 1, 1);
    chk("t1_l_out", 32'(coef_out), 32'h0005);
    chk("t1_l_lane", 32'(coef_lane), 0);
    chk("t1_mag_or", 32'(mag_or), 32'h0007);
    tick;
    chk("t1_h_out", 32'(coef_out), 32'h8003);
    chk("t1_h_lane", 32'(coef_lane), 1);
    tick;
    chk("t1_empty", 32'(coef_vld), 0);
    // saturation and zero
    pair(-65536, 40000, 1, 1);
    chk("t2_neg_sat", 32'(coef_out), 32'hFFFF);
    tick;
    chk("t2_pos_sat", 32'(coef_out), 32'h7FFF);
    tick;
    pair(0, 7, 1, 1);
    chk("t2_zero_vld", 32'(coef_vld), 1);
    chk("t2_zero_out", 32'(coef_out), 32'h0000);
    tick; tick;
    chk("t2_mag_or", 32'(mag_or), 32'(exp_or));
    mag_or_clr = 1'b1;
    tick;
    mag_or_clr = 1'b0;
    exp_or = '0;
    chk("t2_mag_clr", 32'(mag_or), 0);
    // fill, overflow, drain
    coef_rdy = 1'b0;
    for (int i = 0; i < 4; i++) begin
      pair(100 * i + 1, -(100 * i + 2), 1, 1);
      if (i == 2) chk("t3_not_full6", 32'(fifo_full), 0);
    end
    chk("t3_full", 32'(fifo_full), 1);
    chk("t3_ovf_pre", 32'(ovf_err), 0);
    pair(500, 600, 0, 1);
    chk("t3_ovf", 32'(ovf_err), 1);
    chk("t3_full_hold", 32'(fifo_full), 1);
    chk("t3_mag_hold", 32'(mag_or), 32'(exp_or));
    coef_rdy = 1'b1;
    for (int i = 0; i < 8; i++) tick;
    chk("t3_drained", 32'(coef_vld), 0);
    chk("t3_ovf_sticky", 32'(ovf_err), 1);
    rst_syn = 1'b1;
    tick;
    rst_syn = 1'b0;
    exp_or = '0;
    chk("t3_ovf_clr", 32'(ovf_err), 0);
    // pointer wrap with alternating push and pop
    for (int i = 0; i < 6; i++) begin
      pair(3 * i + 1, -(3 * i + 2), 1, 1);
      tick;
    end
    tick;
    chk("t4_drained", 32'(coef_vld), 0);
    chk("t4_ovf", 32'(ovf_err), 0);
    // conservative free check with simultaneous pop
    rst_syn = 1'b1;
    tick;
    rst_syn = 1'b0;
    exp_or = '0;
    coef_rdy = 1'b0;
    for (int i = 0; i < 3; i++) pair(40 + i, -(50 + i), 1, 1);
    coef_rdy = 1'b1;
    pair(60, -61, 1, 1);
    chk("t5_cnt6_accept_ovf", 32'(ovf_err), 0);
    pair(70, -71, 0, 1);
    chk("t5_cnt7_drop_ovf", 32'(ovf_err), 1);
    for (int i = 0; i < 6; i++) tick;
    chk("t5_drained", 32'(coef_vld), 0);
    rst_syn = 1'b1;
    tick;
    rst_syn = 1'b0;
    exp_or = '0;
    pair(32'h70, 32'h300, 1, 1);
    chk("t5_mag_pre", 32'(mag_or), 32'h0370);
    mag_or_clr = 1'b1;
    pair(1, 2, 1, 1);
    mag_or_clr = 1'b0;
    chk("t5_mag_clr_push", 32'(mag_or), 32'h0003);
    tick; tick; tick;
    chk("t5_drained2", 32'(coef_vld), 0);
    // input disable and async reset mid-drain
    coef_rdy = 1'b0;
    pair(11, -12, 1, 1);
    pair(13, -14, 1, 1);
    pair(99, 98, 0, 0);
    chk("t6_no_ovf", 32'(ovf_err), 0);
    chk("t6_mag_or", 32'(mag_or), 32'(exp_or));
    coef_rdy = 1'b1;
    tick;
    chk("t6_draining", 32'(coef_vld), 1);
    #2 rst = 1'b0;
    #1;
    chk("t6_async_vld", 32'(coef_vld), 0);
    chk("t6_async_out", 32'(coef_out), 0);
    q.delete();
    exp_or = '0;
    tick;
    rst = 1'b1;
    chk("t6_rst_mag", 32'(mag_or), 0);
    chk("t6_rst_full", 32'(fifo_full), 0);
    pair(21, -22, 1, 1);
    tick;
    tick;
    chk("t6_count0", 32'(coef_vld), 0);
    chk("sb_empty", 32'(q.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
